// File: rtl/ctrl_stall_scoreboard.sv
// ctrl_stall_scoreboard
//   Pipeline stall controller for the D stage. It keeps a shadow of the
//   writers in flight for DEPTH stages after D (slot0=E, slot1=M, ...) and
//   a busy counter for the mult/div unit. Each D-stage source is compared
//   against the youngest matching writer. When a hazard is found, F/D is
//   frozen and a bubble is inserted into E.
//
//   Optional build macro CTRL_STALL_PERF_CNT_EN adds a 32-bit counter of the
//   cycles in which stall is asserted.
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   d_valid         D holds a real instruction
//   d_src_addr      NUM_SRC packed 5-bit source register numbers
//   d_src_tuse      NUM_SRC packed TW-bit Tuse values
//   d_dst_addr      destination register of the D instruction
//   d_dst_we        D instruction writes the register file
//   d_tnew          Tnew of the D instruction on entry to E
//   d_is_md         D instruction uses HI/LO/MDU
//   d_md_start      D instruction starts an MDU operation
//   d_md_is_div     the start is a divide
//   flush           kill the D instruction
//   stall           freeze PC and F/D
//   e_bubble        clear D/E this cycle
//   md_busy         MDU busy counter is non-zero
//   stall_cnt       (CTRL_STALL_PERF_CNT_EN only) stall cycle count, wraps

module ctrl_stall_scoreboard #(
    parameter int NUM_SRC     = 2,
    parameter int DEPTH       = 3,
    parameter int TW          = 2,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  d_valid,
    input  logic [NUM_SRC*5-1:0]  d_src_addr,
    input  logic [NUM_SRC*TW-1:0] d_src_tuse,
    input  logic [4:0]            d_dst_addr,
    input  logic                  d_dst_we,
    input  logic [TW-1:0]         d_tnew,
    input  logic                  d_is_md,
    input  logic                  d_md_start,
    input  logic                  d_md_is_div,
    input  logic                  flush,
    output logic                  stall,
    output logic                  e_bubble,
    output logic                  md_busy
`ifdef CTRL_STALL_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int MDW = $clog2(DIV_CYCLES + 1);

    logic [DEPTH-1:0][4:0]    slot_addr;
    logic [DEPTH-1:0]         slot_we;
    logic [DEPTH-1:0][TW-1:0] slot_tnew;
    logic [MDW-1:0]           md_cnt;
    logic [NUM_SRC-1:0]       src_hz;
    logic                     accept;

    // Scan from the oldest slot to the youngest so that the youngest match
    // overwrites the verdict of any older one, even when its tnew is zero.
    always_comb begin
        src_hz = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (slot_we[k] && (slot_addr[k] == d_src_addr[5*i +: 5])) begin
                    src_hz[i] = (slot_tnew[k] > d_src_tuse[TW*i +: TW]);
                end
            end
            if (d_src_addr[5*i +: 5] == 5'd0) begin
                src_hz[i] = 1'b0;
            end
        end
    end

    assign md_busy  = (md_cnt != '0);
    assign stall    = d_valid && ((|src_hz) || (d_is_md && md_busy));
    assign e_bubble = stall || flush;
    assign accept   = d_valid && !stall && !flush;

    // Slots past E keep moving during a stall; only the entry into E is
    // replaced by a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_addr <= '0;
            slot_we   <= '0;
            slot_tnew <= '0;
        end else begin
            slot_addr[0] <= accept ? d_dst_addr : 5'd0;
            slot_we[0]   <= accept && d_dst_we && (d_dst_addr != 5'd0);
            slot_tnew[0] <= accept ? d_tnew : '0;
            for (int k = 1; k < DEPTH; k++) begin
                slot_addr[k] <= slot_addr[k-1];
                slot_we[k]   <= slot_we[k-1];
                slot_tnew[k] <= (slot_tnew[k-1] != '0) ? slot_tnew[k-1] - TW'(1) : '0;
            end
        end
    end

    // A start that arrives while busy is held off by the stall, so the
    // counter is only reloaded once that start is actually accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (accept && d_md_start) begin
            md_cnt <= d_md_is_div ? MDW'(DIV_CYCLES) : MDW'(MULT_CYCLES);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - MDW'(1);
        end
    end

`ifdef CTRL_STALL_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 32'd0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
